// File: rtl/cipher_iter_pkg.sv
// cipher_iter_pkg: AES S-box, FSM encoding, key-length to round-count mapping and round helpers
package cipher_iter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    localparam int NR_NK4 = 10;
    localparam int NR_NK6 = 12;
    localparam int NR_NK8 = 14;

    // FIPS-197 S-box, entry 0 in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int nk2nr(input int k);
        return (k == 8) ? NR_NK8 : (k == 6) ? NR_NK6 : NR_NK4;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES encryption round, MixColumns skipped when i_final is set
module aes_round_comb
    import cipher_iter_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic         i_final,
    output logic [127:0] o_state
);

    logic [127:0] w_sr;
    logic [127:0] w_mc;

    // SubBytes and ShiftRows: row r of column c comes from column (c+r) mod 4
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[127 - 8 * (4 * c + r) -: 8] = sbox(i_state[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
    end

    // MixColumns per column
    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++)
            w_mc[127 - 32 * c -: 32] = mix_col(w_sr[127 - 32 * c -: 32]);
    end

    assign o_state = (i_final ? w_sr : w_mc) ^ i_key;

endmodule

// File: rtl/cipher_iter.sv
// cipher_iter: iterative AES encryptor, one round per clock, expanded key supplied unregistered
module cipher_iter
    import cipher_iter_pkg::*;
#(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*nb*(nr+1)-1:0]   w,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              data_out,
    output logic                      busy
);

    // the last round never goes beyond the keys present in w
    localparam logic [3:0] LAST = 4'((nk2nr(nk) < nr) ? nk2nr(nk) : nr);

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic [3:0]   w_kidx;
    logic [127:0] w_rkey;
    logic [127:0] w_round;
    logic         w_last;
    logic         w_accept;

    assign w_last    = r_cnt == LAST;
    assign w_accept  = r_fsm == S_IDLE && in_valid;
    assign in_ready  = r_fsm == S_IDLE;
    assign out_valid = r_fsm == S_DONE;
    assign busy      = r_fsm == S_ROUND;
    assign data_out  = r_state;

    // round key select: key 0 while idle (whitening on accept), else key r_cnt
    always_comb begin
        w_kidx = (r_fsm == S_ROUND) ? r_cnt : 4'd0;
        w_rkey = '0;
        for (int c = 0; c < 4; c++)
            w_rkey[127 - 32 * c -: 32] = w[32 * (4 * int'(w_kidx) + c) +: 32];
    end

    aes_round_comb u_round (
        .i_state (r_state),
        .i_key   (w_rkey),
        .i_final (w_last),
        .o_state (w_round)
    );

    // next-state logic
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  w_fsm_nxt = in_valid ? S_ROUND : S_IDLE;
            S_ROUND: w_fsm_nxt = w_last ? S_DONE : S_ROUND;
            S_DONE:  w_fsm_nxt = out_ready ? S_IDLE : S_DONE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // state, counter and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= '0;
            r_state <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_state <= data_in ^ w_rkey;
                r_cnt   <= 4'd1;
            end else if (r_fsm == S_ROUND) begin
                r_state <= w_round;
                if (!w_last) r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cipher_iter.sv
// tb_cipher_iter: directed FIPS-197 vectors, back-pressure and reset-abort checks for nk 4/6/8
module tb_cipher_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic         iv [3];
    logic         ordy [3];
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [127:0] dout [3];
    logic [1919:0] wk [3];
    logic [7:0]   tb_sbox [256];
    int           n_vec = 0;
    int           n_err = 0;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY4  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY6  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    cipher_iter #(.nk(4), .nb(4), .nr(10)) u4 (
        .clk(clk), .rst(rst), .w(wk[0][1407:0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_in(din), .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]), .busy(bz[0]));
    cipher_iter #(.nk(6), .nb(4), .nr(12)) u6 (
        .clk(clk), .rst(rst), .w(wk[1][1663:0]), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_in(din), .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]), .busy(bz[1]));
    cipher_iter #(.nk(8), .nb(4), .nr(14)) u8 (
        .clk(clk), .rst(rst), .w(wk[2][1919:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .data_in(din), .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout[2]), .busy(bz[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0] wd [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [1919:0] res;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) wd[i] = key[255 - 32 * i -: 32];
            else begin
                t = wd[i - 1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                wd[i] = wd[i - nk] ^ t;
            end
            res[32 * i +: 32] = wd[i];
        end
        return res;
    endfunction

    task automatic accept(input int u, input logic [127:0] pt);
        @(negedge clk);
        din   = pt;
        iv[u] = 1'b1;
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
        din   = ~pt;
    endtask

    task automatic wait_done(input int u, input int n0, input int lat, input string tag);
        int n = n0;
        while (!ov[u] && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(lat));
    endtask

    task automatic release_out(input int u, input string tag);
        @(negedge clk);
        ordy[u] = 1'b1;
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
        check({tag, " ov after ack"}, ov[u], 0);
        check({tag, " rdy after ack"}, ir[u], 1);
    endtask

    task automatic run(input int u, input logic [127:0] pt, input logic [127:0] ct, input int lat, input string tag);
        accept(u, pt);
        check({tag, " busy"}, bz[u], 1);
        check({tag, " rdy in round"}, ir[u], 0);
        wait_done(u, 1, lat, tag);
        check({tag, " data"}, dout[u], ct);
        release_out(u, tag);
    endtask

    initial begin
        logic [7:0] inv;
        rst = 1'b1;
        din = '0;
        for (int u = 0; u < 3; u++) begin
            iv[u]   = 1'b0;
            ordy[u] = 1'b0;
        end
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        wk[0] = expand(KEY4, 4);
        wk[1] = expand(KEY6, 6);
        wk[2] = expand(KEY8, 8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check("reset ov", ov[u], 0);
            check("reset rdy", ir[u], 1);
            check("reset busy", bz[u], 0);
            check("reset data", dout[u], 0);
        end

        run(0, PT, CT4, 11, "nk4 C.1");
        wk[0] = expand(KEY_B, 4);
        run(0, PT_B, CT_B, 11, "nk4 B");
        run(1, PT, CT6, 13, "nk6 C.2");
        run(2, PT, CT8, 15, "nk8 C.3");

        wk[0] = expand(KEY4, 4);
        accept(0, PT);
        repeat (3) begin
            @(negedge clk);
            iv[0] = 1'b1;
            din   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            iv[0] = 1'b0;
        end
        check("bp busy after pulses", bz[0], 1);
        wait_done(0, 4, 11, "bp");
        check("bp data", dout[0], CT4);
        iv[0] = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("bp hold data", dout[0], CT4);
            check("bp hold ov", ov[0], 1);
            check("bp hold rdy", ir[0], 0);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        iv[0]   = 1'b0;
        check("bp ack ov", ov[0], 0);
        check("bp ack idle", ir[0], 1);
        check("bp no accept on ack", bz[0], 0);
        @(posedge clk);
        #1;
        check("bp still idle", ir[0], 1);

        accept(0, PT_B);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort ov", ov[0], 0);
        check("abort data", dout[0], 0);
        check("abort rdy", ir[0], 1);
        check("abort busy", bz[0], 0);
        run(0, PT, CT4, 11, "after abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
